// File: rtl/ccc_rst_pkg.sv
// Shared types and constants for the CCC reset/power-up sequencer.
package ccc_rst_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_LOCK_STABLE = 3'd1,
        ST_CAM_RESET   = 3'd2,
        ST_CAM_SETTLE  = 3'd3,
        ST_RUN         = 3'd4
    } rst_state_e;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 4096;
    localparam int DEF_CAM_RESET_CYCLES   = 400;
    localparam int DEF_CAM_SETTLE_CYCLES  = 40000;

    // Width of the shared counter: it only has to reach (largest count - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ccc_lock_synchronizer.sv
// Multi-flop synchroniser bringing the asynchronous CCC LOCK into the GL0 domain.
module ccc_lock_synchronizer
    import ccc_rst_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lock_async,
    output logic lock_q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw lock level one stage further down the chain each cycle.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], lock_async};
    end

    // Chain flops; reset flushes the chain so lock reads low after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign lock_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ccc_reset_sequencer.sv
// Reset/power-up sequencer downstream of the CCC: qualifies LOCK, then
// releases camera power-down/reset and finally the fabric reset.
// Optional build macro CCC_RST_CAM_SEQ_EN enables the camera PWDN/RESET
// phases; without it LOCK_STABLE leads straight to RUN, CAM_PWDN is tied
// low and CAM_RESET_N follows FABRIC_RESET_N.
module ccc_reset_sequencer
    import ccc_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int CAM_RESET_CYCLES   = DEF_CAM_RESET_CYCLES,
    parameter int CAM_SETTLE_CYCLES  = DEF_CAM_SETTLE_CYCLES
) (
    input  logic GL0,
    input  logic RESET_N,
    input  logic LOCK,
    output logic FABRIC_RESET_N,
    output logic CAM_PWDN,
    output logic CAM_RESET_N,
    output logic SYS_READY,
    output logic LOCK_LOST
);

    localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, CAM_RESET_CYCLES, CAM_SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef CCC_RST_CAM_SEQ_EN
    localparam logic [CNT_W-1:0] CR_LAST = CNT_W'(CAM_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CS_LAST = CNT_W'(CAM_SETTLE_CYCLES - 1);
`endif

    logic             lock_q;
    rst_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fabric_reset_n_q, fabric_reset_n_d;
    logic             sys_ready_q, sys_ready_d;
    logic             lock_lost_q, lock_lost_d;
`ifdef CCC_RST_CAM_SEQ_EN
    logic             cam_pwdn_q, cam_pwdn_d;
    logic             cam_reset_n_q, cam_reset_n_d;
`endif

    ccc_lock_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk        (GL0),
        .rst_n      (RESET_N),
        .lock_async (LOCK),
        .lock_q     (lock_q)
    );

    // Next-state and counter logic; lock loss overrides any count-done exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_q) begin
                    state_d = ST_LOCK_STABLE;
                    cnt_d   = '0;
                end
            end
            ST_LOCK_STABLE: begin
                if (cnt_q == LS_LAST) begin
`ifdef CCC_RST_CAM_SEQ_EN
                    state_d = ST_CAM_RESET;
`else
                    state_d = ST_RUN;
`endif
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef CCC_RST_CAM_SEQ_EN
            ST_CAM_RESET: begin
                if (cnt_q == CR_LAST) begin
                    state_d = ST_CAM_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAM_SETTLE: begin
                if (cnt_q == CS_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        if (!lock_q && (state_q != ST_WAIT_LOCK)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
        end
    end

    // Output decode from the next state so outputs move on the same edge as the FSM.
    always_comb begin
        fabric_reset_n_d = (state_d == ST_RUN);
        sys_ready_d      = (state_d == ST_RUN);
        lock_lost_d      = lock_lost_q | ((state_q == ST_RUN) && !lock_q);
`ifdef CCC_RST_CAM_SEQ_EN
        cam_pwdn_d       = (state_d == ST_WAIT_LOCK) || (state_d == ST_LOCK_STABLE);
        cam_reset_n_d    = (state_d == ST_CAM_SETTLE) || (state_d == ST_RUN);
`endif
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge GL0) begin
        if (!RESET_N) begin
            state_q          <= ST_WAIT_LOCK;
            cnt_q            <= '0;
            fabric_reset_n_q <= 1'b0;
            sys_ready_q      <= 1'b0;
            lock_lost_q      <= 1'b0;
`ifdef CCC_RST_CAM_SEQ_EN
            cam_pwdn_q       <= 1'b1;
            cam_reset_n_q    <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            fabric_reset_n_q <= fabric_reset_n_d;
            sys_ready_q      <= sys_ready_d;
            lock_lost_q      <= lock_lost_d;
`ifdef CCC_RST_CAM_SEQ_EN
            cam_pwdn_q       <= cam_pwdn_d;
            cam_reset_n_q    <= cam_reset_n_d;
`endif
        end
    end

    assign FABRIC_RESET_N = fabric_reset_n_q;
    assign SYS_READY      = sys_ready_q;
    assign LOCK_LOST      = lock_lost_q;
`ifdef CCC_RST_CAM_SEQ_EN
    assign CAM_PWDN       = cam_pwdn_q;
    assign CAM_RESET_N    = cam_reset_n_q;
`else
    assign CAM_PWDN       = 1'b0;
    assign CAM_RESET_N    = fabric_reset_n_q;
`endif

endmodule

// File: tb/tb_ccc_reset_sequencer.sv
// Bench for ccc_reset_sequencer with small count parameters; expectations
// follow CCC_RST_CAM_SEQ_EN as seen at compile time.
module tb_ccc_reset_sequencer;

    localparam int N_ROWS = 22;

`ifdef CCC_RST_CAM_SEQ_EN
    localparam logic EXP_PWDN_IDLE   = 1'b1;
    localparam int   EXP_PWDN_FALL   = 10;
    localparam int   EXP_CAMRST_RISE = 14;
    localparam int   EXP_FAB_RISE    = 20;
`else
    localparam logic EXP_PWDN_IDLE   = 1'b0;
    localparam int   EXP_PWDN_FALL   = 10;
    localparam int   EXP_CAMRST_RISE = 10;
    localparam int   EXP_FAB_RISE    = 10;
`endif

    typedef struct {
        logic reset_n;
        logic lock;
        logic fab;
        logic pwdn;
        logic camrst;
        logic rdy;
    } vec_t;

    logic GL0     = 1'b0;
    logic RESET_N = 1'b0;
    logic LOCK    = 1'b0;
    logic FABRIC_RESET_N;
    logic CAM_PWDN;
    logic CAM_RESET_N;
    logic SYS_READY;
    logic LOCK_LOST;

    int   testsRun    = 0;
    int   testsFailed = 0;
    vec_t vecs [N_ROWS];

    ccc_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .CAM_RESET_CYCLES   (4),
        .CAM_SETTLE_CYCLES  (6)
    ) dut (
        .GL0            (GL0),
        .RESET_N        (RESET_N),
        .LOCK           (LOCK),
        .FABRIC_RESET_N (FABRIC_RESET_N),
        .CAM_PWDN       (CAM_PWDN),
        .CAM_RESET_N    (CAM_RESET_N),
        .SYS_READY      (SYS_READY),
        .LOCK_LOST      (LOCK_LOST)
    );

    // Free-running GL0, 10 ns period.
    always #5 GL0 = ~GL0;

    // Drive inputs, let one rising edge sample them, then settle 1 ns past it.
    task automatic applyStimulus(input logic rn, input logic lk);
        RESET_N = rn;
        LOCK    = lk;
        @(posedge GL0);
        #1;
    endtask

    // Compare all five outputs against the expected values as one test.
    task automatic checkOutput(input string name, input logic fab, input logic pwdn,
                               input logic camrst, input logic rdy, input logic lost);
        testsRun++;
        if ({FABRIC_RESET_N, CAM_PWDN, CAM_RESET_N, SYS_READY, LOCK_LOST} !==
            {fab, pwdn, camrst, rdy, lost}) begin
            testsFailed++;
            $display("[TB] FAIL %s: got fab=%b pwdn=%b camrst=%b rdy=%b lost=%b, expected fab=%b pwdn=%b camrst=%b rdy=%b lost=%b",
                     name, FABRIC_RESET_N, CAM_PWDN, CAM_RESET_N, SYS_READY, LOCK_LOST,
                     fab, pwdn, camrst, rdy, lost);
        end
    endtask

    // Row n: LOCK held high, outputs expected after the n-th edge since LOCK was first sampled high.
    task automatic fillTable();
        for (int n = 0; n < N_ROWS; n++) begin
            vecs[n].reset_n = 1'b1;
            vecs[n].lock    = 1'b1;
            vecs[n].pwdn    = (n < EXP_PWDN_FALL) ? EXP_PWDN_IDLE : 1'b0;
            vecs[n].camrst  = (n >= EXP_CAMRST_RISE);
            vecs[n].fab     = (n >= EXP_FAB_RISE);
            vecs[n].rdy     = (n >= EXP_FAB_RISE);
        end
    endtask

    // Play the first nRows vectors with the given expected LOCK_LOST level.
    task automatic runTable(input logic expLost, input int nRows, input string tag);
        for (int i = 0; i < nRows; i++) begin
            applyStimulus(vecs[i].reset_n, vecs[i].lock);
            checkOutput($sformatf("%s row %0d", tag, i),
                        vecs[i].fab, vecs[i].pwdn, vecs[i].camrst, vecs[i].rdy, expLost);
        end
    endtask

    // Directed test sequence.
    initial begin
        fillTable();

        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("reset", 1'b0, EXP_PWDN_IDLE, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("no lock %0d", i), 1'b0, EXP_PWDN_IDLE, 1'b0, 1'b0, 1'b0);
        end

        runTable(1'b0, N_ROWS, "startup");

        applyStimulus(1'b1, 1'b0);
        checkOutput("drop edge j", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("drop edge j+1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        runTable(1'b1, N_ROWS, "relock");

        applyStimulus(1'b0, 1'b1);
        checkOutput("reset clears lost", 1'b0, EXP_PWDN_IDLE, 1'b0, 1'b0, 1'b0);
        runTable(1'b0, 16, "presettle");
        applyStimulus(1'b0, 1'b1);
        checkOutput("reset mid settle", 1'b0, EXP_PWDN_IDLE, 1'b0, 1'b0, 1'b0);
        runTable(1'b0, N_ROWS, "after reset");

        applyStimulus(1'b0, 1'b1);
        checkOutput("reset before glitch", 1'b0, EXP_PWDN_IDLE, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("glitch pre %0d", i), 1'b0, EXP_PWDN_IDLE, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("glitch low", 1'b0, EXP_PWDN_IDLE, 1'b0, 1'b0, 1'b0);
        runTable(1'b0, N_ROWS, "glitch");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
